// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic computing blocks (number generator and decoder).
package sc_pkg;

  localparam int unsigned SC_CNT_W = 16;

  localparam logic MODE_UNIPOLAR = 1'b0;
  localparam logic MODE_BIPOLAR  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } sc_state_e;

endpackage

// File: rtl/sc_window_counter.sv
// Consumed-bit and ones counters for one decoding window, with a last-bit flag.
module sc_window_counter
  import sc_pkg::*;
#(
  parameter int unsigned CNT_W = SC_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic             bit_i,
  input  logic [CNT_W-1:0] len_i,
  output logic [CNT_W-1:0] ones_o,
  output logic [CNT_W-1:0] ones_next_c_o,
  output logic             last_c_o
);

  logic [CNT_W-1:0] consumed_q, consumed_d;
  logic [CNT_W-1:0] ones_q, ones_d;

  // Ones count including the bit being offered this cycle.
  assign ones_next_c_o = ones_q + CNT_W'(bit_i);
  assign last_c_o      = (consumed_q == (len_i - CNT_W'(1)));
  assign ones_o        = ones_q;

  always_comb begin
    consumed_d = consumed_q;
    ones_d     = ones_q;
    if (clr_i) begin
      consumed_d = '0;
      ones_d     = '0;
    end else if (inc_i) begin
      consumed_d = consumed_q + CNT_W'(1);
      ones_d     = ones_next_c_o;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      consumed_q <= '0;
      ones_q     <= '0;
    end else begin
      consumed_q <= consumed_d;
      ones_q     <= ones_d;
    end
  end

endmodule

// File: rtl/sc_bitstream_decoder.sv
// Stochastic-to-binary converter: counts ones over a programmable window and
// returns the unipolar count or bipolar value on a valid/ready result port.
module sc_bitstream_decoder
  import sc_pkg::*;
#(
  parameter int unsigned CNT_W = SC_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] win_len,
  input  logic             bipolar,
  input  logic             clear,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  output logic [CNT_W:0]   result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy
);

  localparam int unsigned RES_W = CNT_W + 1;

  sc_state_e        state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             mode_q, mode_d;
  logic [RES_W-1:0] result_q, result_d;
  logic             res_valid_q, res_valid_d;
  logic             bit_ready_q, bit_ready_d;
  logic             busy_q, busy_d;

  logic             cnt_clr, cnt_inc, cnt_last_c;
  logic [CNT_W-1:0] ones, ones_next_c;
  logic             start_ok_c, bit_hs_c;

  sc_window_counter #(.CNT_W(CNT_W)) u_counter (
    .clk           (clk),
    .rst_n         (rst_n),
    .clr_i         (cnt_clr),
    .inc_i         (cnt_inc),
    .bit_i         (bit_in),
    .len_i         (len_q),
    .ones_o        (ones),
    .ones_next_c_o (ones_next_c),
    .last_c_o      (cnt_last_c)
  );

  // Bipolar value 2*ones - len stays within [-len, +len], so CNT_W+1 bits suffice.
  function automatic logic [RES_W-1:0] fmt_result(input logic [CNT_W-1:0] n_ones,
                                                  input logic [CNT_W-1:0] n_len,
                                                  input logic             mode);
    if (mode == MODE_BIPOLAR) begin
      return {n_ones, 1'b0} - {1'b0, n_len};
    end
    return {1'b0, n_ones};
  endfunction

  assign start_ok_c = start && (win_len != '0);
  assign bit_hs_c   = bit_valid && bit_ready_q;

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    mode_d   = mode_q;
    result_d = result_q;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;

    if (clear) begin
      state_d  = ST_IDLE;
      len_d    = '0;
      mode_d   = MODE_UNIPOLAR;
      result_d = '0;
      cnt_clr  = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_ok_c) begin
            state_d = ST_ACCUM;
            len_d   = win_len;
            mode_d  = bipolar;
            cnt_clr = 1'b1;
          end
        end
        ST_ACCUM: begin
          cnt_inc = bit_hs_c;
          if (bit_hs_c && cnt_last_c) begin
            state_d  = ST_DONE;
            result_d = fmt_result(ones_next_c, len_q, mode_q);
          end
        end
        ST_DONE: begin
          if (res_ready) begin
            if (start_ok_c) begin
              state_d = ST_ACCUM;
              len_d   = win_len;
              mode_d  = bipolar;
              cnt_clr = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_clr = 1'b1;
        end
      endcase
    end

    // Handshake outputs are registered copies of the next-state decode.
    bit_ready_d = (state_d == ST_ACCUM);
    res_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      mode_q      <= MODE_UNIPOLAR;
      result_q    <= '0;
      res_valid_q <= 1'b0;
      bit_ready_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      mode_q      <= mode_d;
      result_q    <= result_d;
      res_valid_q <= res_valid_d;
      bit_ready_q <= bit_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign bit_ready = bit_ready_q;
  assign res_valid = res_valid_q;
  assign busy      = busy_q;
  assign result    = result_q;

endmodule

// File: tb/tb_sc_bitstream_decoder.sv
// Scoreboard bench for sc_bitstream_decoder: directed plan cases plus randomized windows.
module tb_sc_bitstream_decoder;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned RES_W = CNT_W + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] win_len = '0;
  logic             bipolar = 1'b0;
  logic             clear = 1'b0;
  logic             bit_in = 1'b0;
  logic             bit_valid = 1'b0;
  logic             res_ready = 1'b0;
  logic             bit_ready;
  logic [RES_W-1:0] result;
  logic             res_valid;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [RES_W-1:0] exp_q[$];

  always #5 clk = ~clk;

  sc_bitstream_decoder #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .win_len   (win_len),
    .bipolar   (bipolar),
    .clear     (clear),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .bit_ready (bit_ready),
    .result    (result),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [RES_W-1:0] act, input logic [RES_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: count ones in the window, then apply the unipolar/bipolar rule.
  function automatic logic [RES_W-1:0] model(input int len, input bit bip, input bit bits[$]);
    int n_ones = 0;
    foreach (bits[i]) n_ones += int'(bits[i]);
    if (bip) return RES_W'(2 * n_ones - len);
    return RES_W'(n_ones);
  endfunction

  // Monitor: every accepted result must match the oldest expected value.
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got 0x%0h, expected none", result);
      end else begin
        check("result", result, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_window(input int len, input bit bip);
    start   = 1'b1;
    win_len = CNT_W'(len);
    bipolar = bip;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input bit bits[$], input int max_gap, input bit poke_start);
    foreach (bits[i]) begin
      int w = 0;
      bit_valid = 1'b0;
      repeat ($urandom_range(max_gap, 0)) tick();
      bit_valid = 1'b1;
      bit_in    = bits[i];
      if (poke_start && i == 1) begin
        start   = 1'b1;
        win_len = CNT_W'($urandom_range(9, 1));
        bipolar = ~bipolar;
      end
      while (!bit_ready && w < 50) begin
        tick();
        w++;
      end
      if (w == 50) check("bit_ready_timeout", 1'b0, 1'b1);
      tick();
      start     = 1'b0;
      bit_valid = 1'b0;
    end
  endtask

  // Hold off the consumer for a while, checking DONE is stable, then accept.
  task automatic drain(input int hold);
    logic [RES_W-1:0] held;
    check("latency_res_valid", res_valid, 1'b1);
    held = result;
    repeat (hold) begin
      tick();
      check("done_res_valid_held", res_valid, 1'b1);
      check("done_result_held", result, held);
      check("done_bit_ready", bit_ready, 1'b0);
      check("done_busy", busy, 1'b1);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("res_valid_drop", res_valid, 1'b0);
    check("idle_busy", busy, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    bit bits[$];
    int len;
    bit bip;

    #12;
    check("reset_result", result, '0);
    check("reset_res_valid", res_valid, 1'b0);
    check("reset_bit_ready", bit_ready, 1'b0);
    check("reset_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Unipolar count of 1,0,1,1,0,0,1,0.
    bits = '{1, 0, 1, 1, 0, 0, 1, 0};
    exp_q.push_back(RES_W'(4));
    start_window(8, 1'b0);
    check("accum_bit_ready", bit_ready, 1'b1);
    check("accum_busy", busy, 1'b1);
    feed(bits, 0, 1'b0);
    drain(0);

    // Bipolar extremes and a balanced stream.
    bits = {};
    repeat (16) bits.push_back(1'b1);
    exp_q.push_back(RES_W'(16));
    start_window(16, 1'b1);
    feed(bits, 0, 1'b0);
    drain(1);
    bits = {};
    repeat (16) bits.push_back(1'b0);
    exp_q.push_back(17'h1FFF0);
    start_window(16, 1'b1);
    feed(bits, 0, 1'b0);
    drain(1);
    bits = '{1, 0, 1, 1, 0, 0, 1, 0};
    exp_q.push_back(RES_W'(0));
    start_window(8, 1'b1);
    feed(bits, 0, 1'b0);
    drain(0);

    // Gaps of 3 cycles between bits and 5 cycles of result backpressure.
    bits = '{1, 1, 0, 1};
    exp_q.push_back(RES_W'(3));
    start_window(4, 1'b0);
    foreach (bits[i]) begin
      bit_valid = 1'b0;
      repeat (3) tick();
      check("gap_bit_ready", bit_ready, 1'b1);
      bit_valid = 1'b1;
      bit_in    = bits[i];
      tick();
      bit_valid = 1'b0;
    end
    check("gap_latency", res_valid, 1'b1);
    check("gap_result", result, RES_W'(3));
    repeat (5) begin
      tick();
      check("bp_result_held", result, RES_W'(3));
      check("bp_bit_ready", bit_ready, 1'b0);
    end

    // Back-to-back: accept result and start the next window together.
    exp_q.push_back(RES_W'(2));
    res_ready = 1'b1;
    start     = 1'b1;
    win_len   = CNT_W'(2);
    bipolar   = 1'b0;
    tick();
    res_ready = 1'b0;
    start     = 1'b0;
    check("b2b_bit_ready", bit_ready, 1'b1);
    check("b2b_res_valid", res_valid, 1'b0);
    check("b2b_busy", busy, 1'b1);
    bits = '{1, 1};
    feed(bits, 0, 1'b0);
    drain(2);

    // Zero-length start is ignored.
    start_window(0, 1'b0);
    check("zero_len_busy", busy, 1'b0);
    check("zero_len_bit_ready", bit_ready, 1'b0);
    repeat (3) begin
      tick();
      check("zero_len_res_valid", res_valid, 1'b0);
    end

    // Start during ACCUM must not disturb the window.
    bits = '{1, 0, 1, 1, 1};
    exp_q.push_back(model(5, 1'b0, bits));
    start_window(5, 1'b0);
    feed(bits, 1, 1'b1);
    drain(1);

    // Single-bit window.
    bits = '{1};
    exp_q.push_back(RES_W'(1));
    start_window(1, 1'b0);
    feed(bits, 0, 1'b0);
    drain(0);

    // Randomized windows.
    for (int t = 0; t < 20; t++) begin
      len  = $urandom_range(40, 1);
      bip  = 1'($urandom_range(1, 0));
      bits = {};
      for (int k = 0; k < len; k++) bits.push_back(1'($urandom_range(1, 0)));
      exp_q.push_back(model(len, bip, bits));
      start_window(len, bip);
      feed(bits, 2, 1'b0);
      drain($urandom_range(3, 0));
    end

    // Clear after 3 of 8 bits discards the window.
    bits = '{1, 1, 1};
    start_window(8, 1'b0);
    feed(bits, 0, 1'b0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_bit_ready", bit_ready, 1'b0);
    check("clear_busy", busy, 1'b0);
    check("clear_res_valid", res_valid, 1'b0);
    check("clear_result", result, '0);
    repeat (3) begin
      tick();
      check("clear_no_result", res_valid, 1'b0);
    end

    // Leave a nonzero result, then reset mid-window.
    bits = '{1};
    exp_q.push_back(RES_W'(1));
    start_window(1, 1'b0);
    feed(bits, 0, 1'b0);
    drain(0);
    bits = '{1, 1};
    start_window(8, 1'b1);
    feed(bits, 0, 1'b0);
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_result", result, '0);
    check("arst_res_valid", res_valid, 1'b0);
    check("arst_bit_ready", bit_ready, 1'b0);
    check("arst_busy", busy, 1'b0);
    bit_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Fresh window of 8 ones after reset.
    bits = {};
    repeat (8) bits.push_back(1'b1);
    exp_q.push_back(RES_W'(8));
    start_window(8, 1'b0);
    feed(bits, 1, 1'b0);
    drain(1);

    tick();
    check("scoreboard_empty", RES_W'(exp_q.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sc_bitstream_decoder.md
Name: sc_bitstream_decoder

Overview:
Stochastic-to-binary converter; the decoding end of the stochastic number generator built on the xorshift RNGs.
- Counts ones in a serial stochastic bitstream over a programmable window.
- Emits the unipolar count, or the bipolar value, as a binary word on a valid/ready result port.
- Sits at the output of stochastic compute chains and feeds host-visible result registers.

Parameters:
CNT_W, 16, width of window length and ones counter; max window 2^CNT_W-1 bits
RES_W, CNT_W+1, result width (derived, not overridable); holds signed bipolar range

Ports:
clk  in  1  system clock, all logic on posedge
rst_n  in  1  asynchronous, active-low reset
start  in  1  request new window; honoured only in IDLE, or in DONE together with res_ready
win_len  in  CNT_W  window length in bits; sampled when start is accepted
bipolar  in  1  0: result = ones count, 1: result = 2*ones - win_len; sampled with start
clear  in  1  synchronous abort; returns to IDLE from any state
bit_in  in  1  stochastic stream bit
bit_valid  in  1  bit_in valid
bit_ready  out  1  block accepts a bit this cycle
result  out  RES_W  decoded value; unipolar zero-extended, bipolar two's complement
res_valid  out  1  result valid
res_ready  in  1  consumer accepts result
busy  out  1  high in ACCUM or DONE

Behaviour:
- Reset (async assert, sync release): state=IDLE; bit_ready=0, res_valid=0, busy=0, result=0; internal counters and latched length/mode cleared.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - start=1 with win_len!=0: latch win_len and bipolar, zero ones/consumed counters, go to ACCUM next cycle.
  - start=1 with win_len==0: ignored; stay IDLE, no result produced.
- ACCUM:
  - bit_ready=1.
  - Handshake = bit_valid && bit_ready. Each handshake increments consumed, and increments ones if bit_in=1.
  - Gaps in bit_valid stall the count; no timeout.
  - On the handshake where consumed == len-1: compute result from the final ones count (including this bit) and register it. Next cycle: state=DONE, res_valid=1.
  - Latency: last accepted bit to res_valid is 1 cycle.
- DONE:
  - bit_ready=0. result and res_valid held stable while res_ready=0.
  - res_ready=1 and start=0: res_valid drops next cycle, go to IDLE.
  - res_ready=1 and start=1 with win_len!=0: back-to-back. Latch the new window and go straight to ACCUM; res_valid=0 next cycle.
- start in ACCUM: ignored.
- Arithmetic:
  - ones counter is CNT_W bits; it cannot overflow because ones <= len <= 2^CNT_W-1.
  - Bipolar: (ones<<1) - len computed in RES_W bits, two's complement, range [-len, +len].
- clear: takes priority over every other input. Next cycle: IDLE, res_valid=0, bit_ready=0, counters zeroed. Any pending result is discarded.
- rst_n low mid-window: immediate return to reset values; the partial window is lost.
- result changes only on the cycle res_valid rises (or on reset/clear, where it goes to 0).

Decomposition:
- Package sc_pkg: CNT_W default; state enum type (IDLE/ACCUM/DONE); localparams MODE_UNIPOLAR=0, MODE_BIPOLAR=1. Shared with the stochastic number generator.
- Sub-module sc_window_counter: holds the consumed and ones counters with load/increment/clear and a last-bit flag.
- FSM and result formatting stay in the top.

Test Plan:
- Unipolar count: CNT_W=16, start with win_len=8, bipolar=0; stream 1,0,1,1,0,0,1,0 with bit_valid held high -> res_valid 1 cycle after 8th bit; result=4 (0x00004).
- Bipolar all ones / all zeros: win_len=16, bipolar=1.
  - 16 ones -> result=16 (0x00010).
  - 16 zeros -> result=-16 (0x1FFF0).
  - 10110010 (win_len=8) -> result=0.
- Backpressure and gaps: win_len=4, bits 1,1,0,1 with bit_valid low 3 cycles between each bit; res_ready low 5 cycles after res_valid -> result=3 held stable; bit_ready=0 throughout DONE; res_valid drops the cycle after res_ready=1.
- Back-to-back: in DONE assert res_ready=1 and start=1 together with win_len=2 -> next cycle ACCUM, bit_ready=1; bits 1,1 -> result=2.
- Boundaries:
  - win_len=0 start -> stays IDLE, busy=0, no res_valid.
  - start in ACCUM -> ignored; count unaffected.
  - win_len=1, bit 1 -> result=1.
- Abort/reset: clear after 3 of 8 bits -> IDLE next cycle, no res_valid. Then rst_n pulsed low mid-window -> all outputs 0 asynchronously. Then a fresh window of 8 ones -> result=8.
